axby_host_drv: RTL and testbench
================================

Name: axby_host_drv

Overview:
- Host-side initiator for the AXBY operand/result handshake. It is the bus master that the AXBY interface FSM responds to.
- It captures an operand pair on a single-cycle request and drives WR twice: first with X on the data bus, then with Y.
- It then waits for RDYP and pulses RD twice to fetch the high and low result halves. It presents the assembled result with a one-cycle done strobe.
- It sits between the system controller and the AXBY compute unit, replacing manual WR/RD sequencing.

Parameters:
DATA_W, 8, width of operand bus and of each result half
WR_HOLD, 2, cycles WR is held high per write (min 1)
RD_HOLD, 2, cycles RD is held high per read (min 2; responder output enable lags RD by one cycle)
TIMEOUT, 255, max cycles waiting for RDYP before abort; 0 = wait forever

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
go  in  1  single-cycle transaction request
x_in  in  DATA_W  X operand, sampled when go accepted
y_in  in  DATA_W  Y operand, sampled when go accepted
busy  out  1  high from the cycle after go is accepted until return to IDLE
WR  out  1  write strobe to responder
RD  out  1  read strobe to responder
dout  out  DATA_W  operand bus to responder
rdyp  in  1  result-ready from responder
din  in  DATA_W  result half from responder (valid while its OEH/OEL is asserted)
result  out  2*DATA_W  {hi,lo} of last completed transaction
done  out  1  one-cycle pulse, result valid
err  out  1  one-cycle pulse on RDYP timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - WR, RD, busy, done, err, dout and result are all 0.
  - Counters are cleared.
- Outputs: all registered; no combinational path from input to output.
- IDLE: on go=1, latch x_in/y_in to internal registers, go to WR_X. go is ignored in any other state.
- WR_X: WR=1, dout=X for exactly WR_HOLD cycles, then GAP1.
- GAP1: WR=0 for 1 cycle, dout=X held, then WR_Y.
- WR_Y: WR=1, dout=Y for WR_HOLD cycles, then GAP2.
- GAP2: WR=0 for 1 cycle, dout=Y, then WAIT.
- WAIT: WR=0, RD=0.
  - rdyp=1 sampled: go to RD_H next cycle, including when rdyp is already high on the first WAIT cycle.
  - Wait counter counts from 1. If TIMEOUT!=0 and the counter reaches TIMEOUT with rdyp=0: pulse err for 1 cycle, go to IDLE. result is unchanged, done is not pulsed.
- RD_H: RD=1 for RD_HOLD cycles. din is latched into hi on the clock edge ending the last RD_H cycle. Then GAP3.
- GAP3: RD=0 for 1 cycle, then RD_L.
- RD_L: RD=1 for RD_HOLD cycles; latch din into lo on the last cycle. Then GAP4.
- GAP4: RD=0 for 1 cycle (responder returns to idle), then DONE.
- DONE: result={hi,lo} and done=1 for exactly 1 cycle, then IDLE. busy=0 from the next cycle, and a new go may be accepted in that cycle.
- Nominal latency from go to done: 2*WR_HOLD + 2*RD_HOLD + 5 + W cycles, where W is the number of WAIT cycles (≥1).
- WR and RD are never high in the same cycle. Each WR/RD high phase is separated by at least 1 low cycle.
- dout is a don't-care in the read states; it holds Y until IDLE.
- rdyp dropping during the read states is ignored.
- Reset asserted mid-transaction aborts immediately. Strobes drop in the same cycle (async) and no done/err pulse is generated.

Test Plan:
- Reset: hold reset=0, toggle go -> WR=RD=busy=done=err=0, result=0, dout=0.
- Nominal (defaults): go with x_in=0x12, y_in=0x34; rdyp rises 4 cycles into WAIT; din=0xAB during first RD, 0xCD during second -> expected response:
  - WR high 2 cycles with dout=0x12, 1 low, 2 high with dout=0x34.
  - RD pattern 2 high / 1 low / 2 high.
  - result=0xABCD with done high exactly 1 cycle; go-to-done latency = 17 cycles.
- go pulsed again while busy with x_in=0xFF -> ignored; second WR phase still drives 0x34, result unaffected.
- TIMEOUT=8, rdyp held 0 -> err pulses once exactly 8 cycles after entering WAIT, no RD, no done, result retains previous value, busy=0 afterwards.
- rdyp already 1 before WAIT -> RD rises on the cycle after the first WAIT cycle (W=1).
- Reset asserted during the second RD_H cycle -> RD=0 immediately, busy=0. A subsequent go runs a full clean transaction with the correct result.

Source files
------------

// File: rtl/axby_host_drv.sv
// Purpose: host-side AXBY initiator; writes X then Y, waits for RDYP, reads result hi then lo.
// Latency: go to done = 2*WR_HOLD + 2*RD_HOLD + 5 + W cycles (W = WAIT cycles, >= 1).
// Backpressure: go is accepted only in IDLE (busy low); RDYP stalls the read phase up to TIMEOUT cycles.
module axby_host_drv #(
    parameter int DATA_W  = 8,
    parameter int WR_HOLD = 2,
    parameter int RD_HOLD = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [DATA_W-1:0]     x_in,
    input  logic [DATA_W-1:0]     y_in,
    output logic                  busy,
    output logic                  WR,
    output logic                  RD,
    output logic [DATA_W-1:0]     dout,
    input  logic                  rdyp,
    input  logic [DATA_W-1:0]     din,
    output logic [2*DATA_W-1:0]   result,
    output logic                  done,
    output logic                  err
);

    // One counter serves both the strobe hold phases and the RDYP wait, so it
    // must cover the largest of the three limits.
    localparam int HOLD_MAX = (WR_HOLD > RD_HOLD) ? WR_HOLD : RD_HOLD;
    localparam int CNT_MAX  = (TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_X,
        ST_GAP1,
        ST_WR_Y,
        ST_GAP2,
        ST_WAIT,
        ST_RD_H,
        ST_GAP3,
        ST_RD_L,
        ST_GAP4,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_timeout;
    logic                w_lat_hi;
    logic                w_lat_lo;
    logic                w_accept;

    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_dout;
    logic [2*DATA_W-1:0] r_result;
    logic                r_busy;
    logic                r_wr;
    logic                r_rd;
    logic                r_done;
    logic                r_err;

    assign w_accept = (r_state == ST_IDLE) && go;

    // Counter restarts at 1 on every state entry, so it holds "cycles spent in this state".
    assign w_cnt_nxt = (w_state_nxt != r_state) ? CNT_W'(1) : r_cnt + CNT_W'(1);

    // Next-state decode plus the single-cycle events (timeout, half-result capture).
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_lat_hi    = 1'b0;
        w_lat_lo    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) w_state_nxt = ST_WR_X;
            end
            ST_WR_X: begin
                if (r_cnt == CNT_W'(WR_HOLD)) w_state_nxt = ST_GAP1;
            end
            ST_GAP1: w_state_nxt = ST_WR_Y;
            ST_WR_Y: begin
                if (r_cnt == CNT_W'(WR_HOLD)) w_state_nxt = ST_GAP2;
            end
            ST_GAP2: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // rdyp wins over a timeout landing in the same cycle.
                if (rdyp) begin
                    w_state_nxt = ST_RD_H;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT))) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_RD_H: begin
                // Responder output enable lags RD, so din is only trusted on the last RD cycle.
                if (r_cnt == CNT_W'(RD_HOLD)) begin
                    w_state_nxt = ST_GAP3;
                    w_lat_hi    = 1'b1;
                end
            end
            ST_GAP3: w_state_nxt = ST_RD_L;
            ST_RD_L: begin
                if (r_cnt == CNT_W'(RD_HOLD)) begin
                    w_state_nxt = ST_GAP4;
                    w_lat_lo    = 1'b1;
                end
            end
            ST_GAP4: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and phase counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operand capture and bus drive; X goes straight onto dout at acceptance, Y is kept for later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y    <= '0;
            r_dout <= '0;
        end else if (w_accept) begin
            r_y    <= y_in;
            r_dout <= x_in;
        end else if (w_state_nxt == ST_WR_Y && r_state == ST_GAP1) begin
            r_dout <= r_y;
        end
    end

    // Result halves and the published result (updated only on a completed transaction).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else begin
            if (w_lat_hi) r_hi <= din;
            if (w_lat_lo) r_lo <= din;
            if (w_state_nxt == ST_DONE) r_result <= {r_hi, r_lo};
        end
    end

    // Strobes and status registered from the next state so every output is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_wr   <= (w_state_nxt == ST_WR_X) || (w_state_nxt == ST_WR_Y);
            r_rd   <= (w_state_nxt == ST_RD_H) || (w_state_nxt == ST_RD_L);
            r_done <= (w_state_nxt == ST_DONE);
            r_err  <= w_timeout;
        end
    end

    assign busy   = r_busy;
    assign WR     = r_wr;
    assign RD     = r_rd;
    assign dout   = r_dout;
    assign result = r_result;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_axby_host_drv.sv
// Purpose: randomized check of axby_host_drv against a cycle-offset reference model.
// Latency: n/a (bench).
// Backpressure: bench plays the AXBY responder, driving rdyp and a lagging din.
module tb_axby_host_drv;

    localparam int DW = 8;
    localparam int WH = 2;
    localparam int RH = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            go;
    logic [DW-1:0]   x_in;
    logic [DW-1:0]   y_in;
    logic            busy;
    logic            WR;
    logic            RD;
    logic [DW-1:0]   dout;
    logic            rdyp;
    logic [DW-1:0]   din;
    logic [2*DW-1:0] result;
    logic            done;
    logic            err;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [2*DW-1:0] last_result;

    axby_host_drv #(
        .DATA_W (DW),
        .WR_HOLD(WH),
        .RD_HOLD(RH),
        .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .WR    (WR),
        .RD    (RD),
        .dout  (dout),
        .rdyp  (rdyp),
        .din   (din),
        .result(result),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One transaction starting at the current negedge (DUT must be idle).
    // d < 0: rdyp already high; otherwise rdyp rises d cycles into WAIT.
    // The expected waveform is computed from cycle offsets relative to the go cycle.
    task automatic run_txn(input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                           input int d, input bit junk, input bit abort);
        int ws, w, rs, done_t, err_t, tend, rd_edges, done_seen;
        bit tmo, exp_wr, exp_rd, exp_busy, exp_done, exp_err, prev_rd;
        logic [2*DW-1:0] exp_res;
        ws     = 2 * WH + 3;
        tmo    = (TO != 0) && (d >= TO);
        w      = (d < 0) ? 1 : d + 1;
        rs     = ws + w;
        done_t = rs + 2 * RH + 2;
        err_t  = ws + TO;
        tend   = tmo ? err_t : done_t + 1;
        go     = 1'b1;
        x_in   = x;
        y_in   = y;
        rdyp   = (d < 0);
        din    = DW'($urandom);
        prev_rd   = 1'b0;
        rd_edges  = 0;
        done_seen = -1;
        for (int t = 1; t <= tend; t++) begin
            @(negedge clk);
            exp_wr   = (t >= 1 && t <= WH) || (t >= WH + 2 && t <= 2 * WH + 1);
            exp_rd   = !tmo && ((t >= rs && t < rs + RH) || (t > rs + RH && t <= rs + 2 * RH));
            exp_busy = tmo ? (t < err_t) : (t <= done_t);
            exp_done = !tmo && (t == done_t);
            exp_err  = tmo && (t == err_t);
            exp_res  = (!tmo && t >= done_t) ? {hi, lo} : last_result;
            chk("wr",     32'(WR),     32'(exp_wr));
            chk("rd",     32'(RD),     32'(exp_rd));
            chk("busy",   32'(busy),   32'(exp_busy));
            chk("done",   32'(done),   32'(exp_done));
            chk("err",    32'(err),    32'(exp_err));
            chk("result", 32'(result), 32'(exp_res));
            if (t <= WH + 1)
                chk("dout_x", 32'(dout), 32'(x));
            else if (t < (tmo ? err_t : rs))
                chk("dout_y", 32'(dout), 32'(y));
            if (done === 1'b1 && done_seen < 0) done_seen = t;
            if (RD && !prev_rd) rd_edges++;
            // Responder model: din valid only once RD has been high for a full cycle.
            din  = (RD && prev_rd) ? ((rd_edges == 1) ? hi : lo) : DW'($urandom);
            prev_rd = RD;
            rdyp = (d < 0) || (t >= ws + d);
            if (junk && t == 2) begin
                go   = 1'b1;
                x_in = 8'hFF;
                y_in = DW'($urandom);
            end else begin
                go   = 1'b0;
                x_in = DW'($urandom);
                y_in = DW'($urandom);
            end
            if (abort && t == rs + 1) begin
                reset = 1'b0;
                #1;
                chk("abort_rd",     32'(RD),     32'd0);
                chk("abort_wr",     32'(WR),     32'd0);
                chk("abort_busy",   32'(busy),   32'd0);
                chk("abort_done",   32'(done),   32'd0);
                chk("abort_err",    32'(err),    32'd0);
                chk("abort_dout",   32'(dout),   32'd0);
                chk("abort_result", 32'(result), 32'd0);
                last_result = '0;
                go   = 1'b0;
                rdyp = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        if (!tmo) begin
            chk("latency", 32'(done_seen), 32'(done_t));
            last_result = {hi, lo};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        x_in  = '0;
        y_in  = '0;
        rdyp  = 1'b0;
        din   = '0;
        last_result = '0;
        #1 reset = 1'b0;
        // Reset held: go toggling must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            go   = ~go;
            x_in = DW'($urandom);
            y_in = DW'($urandom);
            @(negedge clk);
            chk("rst_wr",     32'(WR),     32'd0);
            chk("rst_rd",     32'(RD),     32'd0);
            chk("rst_busy",   32'(busy),   32'd0);
            chk("rst_done",   32'(done),   32'd0);
            chk("rst_err",    32'(err),    32'd0);
            chk("rst_dout",   32'(dout),   32'd0);
            chk("rst_result", 32'(result), 32'd0);
        end
        go    = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Nominal: rdyp four cycles into WAIT, extra go with 0xFF ignored.
        run_txn(8'h12, 8'h34, 8'hAB, 8'hCD, 3, 1'b1, 1'b0);
        // Timeout: rdyp never rises in time; result must stay 0xABCD.
        run_txn(8'h55, 8'h66, 8'h77, 8'h88, 100, 1'b0, 1'b0);
        // rdyp already high before WAIT.
        run_txn(8'h01, 8'h02, 8'h03, 8'h04, -1, 1'b0, 1'b0);
        // rdyp arrives on the very cycle the counter reaches TIMEOUT.
        run_txn(8'hA5, 8'h5A, 8'hC3, 8'h3C, TO - 1, 1'b0, 1'b0);
        // rdyp one cycle too late.
        run_txn(8'h11, 8'h22, 8'h33, 8'h44, TO, 1'b0, 1'b0);
        // Reset during the second RD_H cycle, then a clean transaction.
        run_txn(8'h9A, 8'hBC, 8'hDE, 8'hF0, 0, 1'b0, 1'b1);
        run_txn(8'h5C, 8'hC5, 8'hE1, 8'h1E, 2, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_txn(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                    int'($urandom_range(0, TO + 2)) - 1, 1'($urandom_range(0, 1)), 1'b0);
        end

        @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
